// File: rtl/demux_stripe_n.sv
// One-to-LANES beat demultiplexer with round-robin or explicit lane selection.
// Each lane is a single-entry register slice with its own valid/ready handshake.
module demux_stripe_n #(
  parameter int WIDTH = 8,
  parameter int LANES = 4,
  localparam int LW = $clog2(LANES)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   valid_in,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   ready_in,
  input  logic                   mode,
  input  logic [LW-1:0]          sel,
  input  logic                   align,
  output logic [LANES-1:0]       valid_out,
  output logic [LANES*WIDTH-1:0] data_out,
  input  logic [LANES-1:0]       ready_out,
  output logic [LW-1:0]          lane_ptr
);

  logic [WIDTH-1:0] lane_q [LANES];
  logic [LW-1:0]    tgt;
  logic             accept;

  always_comb begin
    tgt = lane_ptr;
    if (align) begin
      tgt = '0;
    end else if (mode) begin
      tgt = sel;
    end
  end

  // Target lane can take a beat if it is empty or being drained this cycle.
  assign ready_in = !valid_out[tgt] || ready_out[tgt];
  assign accept   = valid_in && ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < LANES; k++) begin
        if (accept && (tgt == LW'(k))) begin
          lane_q[k]    <= data_in;
          valid_out[k] <= 1'b1;
        end else if (valid_out[k] && ready_out[k]) begin
          valid_out[k] <= 1'b0;
        end
      end
    end
  end

  // Power-of-two lane count makes the increment wrap for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_ptr <= '0;
    end else if (accept) begin
      if (!mode) begin
        lane_ptr <= tgt + LW'(1);
      end
    end else if (align) begin
      lane_ptr <= '0;
    end
  end

  always_comb begin
    data_out = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      data_out[k*WIDTH +: WIDTH] = lane_q[k];
    end
  end

endmodule

// File: tb/tb_demux_stripe_n.sv
// Directed vector table for a 4-lane instance plus randomized scoreboard runs
// on 2-lane and 8-lane 16-bit instances.
module tb_demux_stripe_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [7:0]  data_in = '0;
  logic        ready_in;
  logic        mode = 1'b0;
  logic [1:0]  sel = '0;
  logic        align = 1'b0;
  logic [3:0]  valid_out;
  logic [31:0] data_out;
  logic [3:0]  ready_out = '1;
  logic [1:0]  lane_ptr;

  logic         sw_rst = 1'b1;
  logic         s2_vin = 1'b0, s8_vin = 1'b0;
  logic [15:0]  sw_din = '0;
  logic [7:0]   sw_rdy = '1;
  logic         s2_rin, s8_rin;
  logic [1:0]   s2_vo;
  logic [7:0]   s8_vo;
  logic [31:0]  s2_do;
  logic [127:0] s8_do;
  logic [0:0]   s2_ptr;
  logic [2:0]   s8_ptr;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  demux_stripe_n #(.WIDTH(8), .LANES(4)) dut (
    .clk(clk), .reset(rst), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .mode(mode), .sel(sel), .align(align),
    .valid_out(valid_out), .data_out(data_out), .ready_out(ready_out),
    .lane_ptr(lane_ptr)
  );

  demux_stripe_n #(.WIDTH(16), .LANES(2)) dut2 (
    .clk(clk), .reset(sw_rst), .valid_in(s2_vin), .data_in(sw_din),
    .ready_in(s2_rin), .mode(1'b0), .sel(1'b0), .align(1'b0),
    .valid_out(s2_vo), .data_out(s2_do), .ready_out(sw_rdy[1:0]),
    .lane_ptr(s2_ptr)
  );

  demux_stripe_n #(.WIDTH(16), .LANES(8)) dut8 (
    .clk(clk), .reset(sw_rst), .valid_in(s8_vin), .data_in(sw_din),
    .ready_in(s8_rin), .mode(1'b0), .sel(3'b000), .align(1'b0),
    .valid_out(s8_vo), .data_out(s8_do), .ready_out(sw_rdy),
    .lane_ptr(s8_ptr)
  );

  typedef struct {
    logic        vin;
    logic [7:0]  din;
    logic        mode;
    logic [1:0]  sel;
    logic        align;
    logic [3:0]  rdy;
    logic        e_rin;
    logic [3:0]  e_vo;
    logic [1:0]  e_ptr;
    logic [31:0] e_do;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic sweep(input bit big);
    logic [15:0] q[8][$];
    int          lanes;
    int          ptr;
    int          dp;
    bit          vin, erin, rin, drain;
    logic [7:0]  vo;
    logic [127:0] dout;
    lanes = big ? 8 : 2;
    ptr = 0;
    @(negedge clk) sw_rst = 1'b1;
    @(negedge clk) sw_rst = 1'b0;
    for (int c = 0; c < 640; c++) begin
      @(negedge clk);
      drain  = (c >= 600);
      vin    = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
      s2_vin = !big && vin;
      s8_vin = big && vin;
      sw_din = 16'($urandom);
      sw_rdy = drain ? 8'hFF : 8'($urandom);
      #2;
      rin  = big ? s8_rin : s2_rin;
      vo   = big ? s8_vo : {6'b0, s2_vo};
      dout = big ? s8_do : {96'b0, s2_do};
      dp   = big ? int'(s8_ptr) : int'(s2_ptr);
      check(big ? "sw8_ptr" : "sw2_ptr", 128'(dp), 128'(ptr));
      erin = (q[ptr].size() == 0) || sw_rdy[ptr];
      check(big ? "sw8_ready_in" : "sw2_ready_in", 128'(rin), 128'(erin));
      for (int k = 0; k < lanes; k++) begin
        check(big ? "sw8_valid" : "sw2_valid", 128'(vo[k]), 128'(q[k].size() != 0));
        if (q[k].size() != 0 && sw_rdy[k]) begin
          check(big ? "sw8_data" : "sw2_data", 128'(dout[k*16 +: 16]), 128'(q[k][0]));
          void'(q[k].pop_front());
        end
      end
      if (vin && erin) begin
        q[ptr].push_back(sw_din);
        ptr = (ptr + 1) % lanes;
      end
    end
    s2_vin = 1'b0;
    s8_vin = 1'b0;
    @(negedge clk);
    for (int k = 0; k < lanes; k++) begin
      check(big ? "sw8_leftover" : "sw2_leftover", 128'(q[k].size()), 128'(0));
    end
    check(big ? "sw8_final_valid" : "sw2_final_valid", 128'(vo), 128'(0));
  endtask

  initial begin
    // vin din mode sel align rdy | e_rin e_vo e_ptr e_do
    vq.push_back('{1'b1, 8'h10, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h1, 2'd1, 32'h00000010});
    vq.push_back('{1'b1, 8'h12, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h2, 2'd2, 32'h00001210});
    vq.push_back('{1'b1, 8'h0A, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h4, 2'd3, 32'h000A1210});
    vq.push_back('{1'b1, 8'h14, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h8, 2'd0, 32'h140A1210});
    vq.push_back('{1'b1, 8'h1C, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h1, 2'd1, 32'h140A121C});
    vq.push_back('{1'b0, 8'hEE, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 2'd1, 32'h140A121C});
    vq.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'hF, 1'b1, 4'h0, 2'd0, 32'h140A121C});
    vq.push_back('{1'b1, 8'h21, 1'b0, 2'd0, 1'b0, 4'hD, 1'b1, 4'h1, 2'd1, 32'h140A1221});
    vq.push_back('{1'b1, 8'h13, 1'b0, 2'd0, 1'b0, 4'hD, 1'b1, 4'h2, 2'd2, 32'h140A1321});
    vq.push_back('{1'b1, 8'h23, 1'b0, 2'd0, 1'b0, 4'hD, 1'b1, 4'h6, 2'd3, 32'h14231321});
    vq.push_back('{1'b1, 8'h24, 1'b0, 2'd0, 1'b0, 4'hD, 1'b1, 4'hA, 2'd0, 32'h24231321});
    vq.push_back('{1'b1, 8'h25, 1'b0, 2'd0, 1'b0, 4'hD, 1'b1, 4'h3, 2'd1, 32'h24231325});
    vq.push_back('{1'b1, 8'h26, 1'b0, 2'd0, 1'b0, 4'hD, 1'b0, 4'h2, 2'd1, 32'h24231325});
    vq.push_back('{1'b1, 8'h26, 1'b0, 2'd0, 1'b0, 4'hD, 1'b0, 4'h2, 2'd1, 32'h24231325});
    vq.push_back('{1'b1, 8'h26, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h2, 2'd2, 32'h24232625});
    vq.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 2'd2, 32'h24232625});
    vq.push_back('{1'b1, 8'hAA, 1'b1, 2'd3, 1'b0, 4'hF, 1'b1, 4'h8, 2'd2, 32'hAA232625});
    vq.push_back('{1'b1, 8'hBB, 1'b1, 2'd3, 1'b0, 4'hF, 1'b1, 4'h8, 2'd2, 32'hBB232625});
    vq.push_back('{1'b1, 8'h33, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h4, 2'd3, 32'hBB332625});
    vq.push_back('{1'b1, 8'h55, 1'b0, 2'd0, 1'b1, 4'hF, 1'b1, 4'h1, 2'd1, 32'hBB332655});
    vq.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b1, 4'hF, 1'b1, 4'h0, 2'd0, 32'hBB332655});
    vq.push_back('{1'b1, 8'h66, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h1, 2'd1, 32'hBB332666});
    vq.push_back('{1'b1, 8'h77, 1'b1, 2'd2, 1'b0, 4'hB, 1'b1, 4'h4, 2'd1, 32'hBB772666});
    vq.push_back('{1'b1, 8'h88, 1'b1, 2'd2, 1'b0, 4'hB, 1'b0, 4'h4, 2'd1, 32'hBB772666});
    vq.push_back('{1'b0, 8'h00, 1'b1, 2'd0, 1'b1, 4'hB, 1'b1, 4'h4, 2'd0, 32'hBB772666});
    vq.push_back('{1'b1, 8'h99, 1'b1, 2'd1, 1'b1, 4'hF, 1'b1, 4'h1, 2'd0, 32'hBB772699});
    vq.push_back('{1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 4'hF, 1'b1, 4'h0, 2'd0, 32'hBB772699});

    #1;
    check("reset_valid", 128'(valid_out), 128'(0));
    check("reset_data", 128'(data_out), 128'(0));
    check("reset_ptr", 128'(lane_ptr), 128'(0));
    check("reset_ready_in", 128'(ready_in), 128'(1));
    @(negedge clk) rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      valid_in = vq[i].vin; data_in = vq[i].din; mode = vq[i].mode;
      sel = vq[i].sel; align = vq[i].align; ready_out = vq[i].rdy;
      #1;
      check($sformatf("v%0d_ready_in", i), 128'(ready_in), 128'(vq[i].e_rin));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid_out", i), 128'(valid_out), 128'(vq[i].e_vo));
      check($sformatf("v%0d_lane_ptr", i), 128'(lane_ptr), 128'(vq[i].e_ptr));
      check($sformatf("v%0d_data_out", i), 128'(data_out), 128'(vq[i].e_do));
    end

    // Fill three lanes under full backpressure, then reset between edges.
    ready_out = 4'h0; mode = 1'b0; align = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      @(negedge clk);
      valid_in = 1'b1; data_in = 8'(b);
    end
    @(negedge clk);
    valid_in = 1'b0;
    check("fill_valid", 128'(valid_out), 128'(4'h7));
    check("fill_ptr", 128'(lane_ptr), 128'(3));
    #2;
    rst = 1'b1; valid_in = 1'b1; data_in = 8'h44;
    #1;
    check("async_rst_valid", 128'(valid_out), 128'(0));
    check("async_rst_data", 128'(data_out), 128'(0));
    check("async_rst_ptr", 128'(lane_ptr), 128'(0));
    check("rst_ready_in", 128'(ready_in), 128'(1));
    @(posedge clk);
    #1;
    check("rst_hold_valid", 128'(valid_out), 128'(0));
    check("rst_hold_data", 128'(data_out), 128'(0));
    @(negedge clk);
    rst = 1'b0; ready_out = 4'hF; data_in = 8'h01;
    @(posedge clk);
    #1;
    check("post_rst_valid", 128'(valid_out), 128'(4'h1));
    check("post_rst_data", 128'(data_out), 128'(32'h00000001));
    check("post_rst_ptr", 128'(lane_ptr), 128'(1));
    @(negedge clk) valid_in = 1'b0;

    sweep(1'b0);
    sweep(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
